// File: rtl/mano_pkg.sv
// mano_pkg: bus-select codes, opcode decode indices and default SC width for mano_seq_ctrl.
package mano_pkg;
    localparam int SC_W_DEF = 3;
    localparam logic [2:0] BUS_AR  = 3'd1;
    localparam logic [2:0] BUS_PC  = 3'd2;
    localparam logic [2:0] BUS_IR  = 3'd5;
    localparam logic [2:0] BUS_TR  = 3'd6;
    localparam logic [2:0] BUS_MEM = 3'd7;
    localparam int D_AND = 0;
    localparam int D_ADD = 1;
    localparam int D_LDA = 2;
    localparam int D_STA = 3;
    localparam int D_BUN = 4;
    localparam int D_BSA = 5;
    localparam int D_ISZ = 6;
    localparam int D_REG = 7;
endpackage

// File: rtl/mano_sc_timing.sv
// mano_sc_timing: sequence counter with one-hot T decode; clear wins over increment.
module mano_sc_timing
    import mano_pkg::*;
#(
    parameter int SC_W = SC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clr,
    output logic [SC_W-1:0]      sc,
    output logic [2**SC_W-1:0]   t,
    output logic                 wrap
);
    localparam int N = 2**SC_W;
    localparam logic [N-1:0] ONE = N'(1);
    logic [SC_W-1:0] sc_d, sc_q;
    always_comb begin
        sc_d = run ? (clr ? '0 : sc_q + 1'b1) : sc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) sc_q <= '0;
        else     sc_q <= sc_d;
    end
    assign sc   = sc_q;
    assign t    = run ? ONE << sc_q : '0;
    assign wrap = run && !clr && (&sc_q);
endmodule

// File: rtl/mano_seq_ctrl.sv
// mano_seq_ctrl: Mano basic-computer timing/sequencing controller (fetch, decode, indirect).
// Define INTR_EN to add the interrupt cycle (R flip-flop and its T0..T2 strobes).
module mano_seq_ctrl
    import mano_pkg::*;
#(
    parameter int SC_W    = SC_W_DEF,
    parameter int HLT_BIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          ir,
    input  logic                 exec_done,
    input  logic                 ien,
    input  logic                 fgi,
    input  logic                 fgo,
    output logic [2**SC_W-1:0]   t,
    output logic [7:0]           d,
    output logic                 i_ff,
    output logic                 s_ff,
    output logic                 r_ff,
    output logic                 ar_ld,
    output logic                 ar_inc,
    output logic                 ar_clr,
    output logic                 ir_ld,
    output logic                 pc_inc,
    output logic                 pc_clr,
    output logic                 tr_ld,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 ien_clr,
    output logic [2:0]           bus_sel,
    output logic                 seq_err
);
    localparam int N = 2**SC_W;
    logic s_q, s_d, i_q, i_d, r_q, r_d, err_q, err_d;
    logic [7:0] d_q, d_d;
    logic [SC_W-1:0] sc;
    logic [N-1:0] t_raw, tv;
    logic clr, wrap, ind;
    logic unused_ok;
    mano_sc_timing #(.SC_W(SC_W)) u_sc (
        .clk  (clk),
        .rst  (rst),
        .run  (s_q),
        .clr  (clr),
        .sc   (sc),
        .t    (t_raw),
        .wrap (wrap)
    );
    always_comb begin
        clr   = (exec_done && sc >= SC_W'(4)) || (t_raw[3] && d_q[D_REG]) || (r_q && t_raw[2]);
        s_d   = (!s_q && start) ? 1'b1 :
                (t_raw[3] && d_q[D_REG] && !i_q && ir[HLT_BIT]) ? 1'b0 : s_q;
        d_d   = (t_raw[2] && !r_q) ? 8'd1 << ir[14:12] : d_q;
        i_d   = (t_raw[2] && !r_q) ? ir[15] : i_q;
        err_d = err_q | wrap;
`ifdef INTR_EN
        r_d   = (r_q && t_raw[2]) ? 1'b0 :
                (s_q && sc >= SC_W'(3) && ien && (fgi || fgo)) ? 1'b1 : r_q;
`else
        r_d   = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 1'b0;
            i_q   <= 1'b0;
            r_q   <= 1'b0;
            err_q <= 1'b0;
            d_q   <= '0;
        end else begin
            s_q   <= s_d;
            i_q   <= i_d;
            r_q   <= r_d;
            err_q <= err_d;
            d_q   <= d_d;
        end
    end
    // Strobes are masked in the reset cycle even if an instruction was in flight.
    assign tv  = rst ? '0 : t_raw;
    assign ind = tv[3] && !d_q[D_REG] && i_q;
    always_comb begin
        ar_ld   = !r_q && (tv[0] || tv[2] || ind);
        ar_inc  = 1'b0;
        ar_clr  = r_q && tv[0];
        tr_ld   = r_q && tv[0];
        ir_ld   = !r_q && tv[1];
        mem_rd  = !r_q && (tv[1] || ind);
        mem_wr  = r_q && tv[1];
        pc_clr  = r_q && tv[1];
        pc_inc  = (!r_q && tv[1]) || (r_q && tv[2]);
        ien_clr = r_q && tv[2];
        bus_sel = tv[0] ? BUS_PC :
                  tv[1] ? (r_q ? BUS_TR : BUS_MEM) :
                  (tv[2] && !r_q) ? BUS_IR :
                  (ind && !r_q) ? BUS_MEM : 3'd0;
    end
    assign t         = tv;
    assign d         = d_q;
    assign i_ff      = i_q;
    assign s_ff      = s_q;
    assign r_ff      = r_q && s_q;
    assign seq_err   = err_q;
    assign unused_ok = ^{ien, fgi, fgo, ir};
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// tb_mano_seq_ctrl: directed and random checks of mano_seq_ctrl against an instruction-level model.
module tb_mano_seq_ctrl;
    logic clk = 1'b0;
    logic rst, start, exec_done, ien, fgi, fgo;
    logic [15:0] ir;
    logic [7:0] t, d;
    logic i_ff, s_ff, r_ff, ar_ld, ar_inc, ar_clr, ir_ld, pc_inc, pc_clr, tr_ld;
    logic mem_rd, mem_wr, ien_clr, seq_err;
    logic [2:0] bus_sel;
    int checks = 0, failures = 0;
    logic [32:0] e;
    int m_sc = 0;
    bit m_s = 0, m_i = 0, m_r = 0, m_err = 0;
    logic [7:0] m_d = 8'd0;
    always #5 clk = ~clk;
    mano_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .exec_done(exec_done),
        .ien(ien), .fgi(fgi), .fgo(fgo), .t(t), .d(d), .i_ff(i_ff), .s_ff(s_ff),
        .r_ff(r_ff), .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr), .ir_ld(ir_ld),
        .pc_inc(pc_inc), .pc_clr(pc_clr), .tr_ld(tr_ld), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .ien_clr(ien_clr), .bus_sel(bus_sel), .seq_err(seq_err)
    );
    wire [32:0] obs = {t, d, i_ff, s_ff, r_ff, ar_ld, ar_inc, ar_clr, ir_ld, pc_inc,
                       pc_clr, tr_ld, mem_rd, mem_wr, ien_clr, bus_sel, seq_err};
    function automatic logic [32:0] exp_vec();
        logic [7:0] tt;
        logic al, ac, il, pi, pc, tl, mr, mw, ic;
        logic [2:0] bs;
        {al, ac, il, pi, pc, tl, mr, mw, ic} = '0;
        bs = 3'd0;
        tt = (m_s && !rst) ? 8'(1 << m_sc) : 8'd0;
        if (m_s && !rst) begin
            if (!m_r) begin
                if (m_sc == 0) begin al = 1; bs = 3'd2; end
                if (m_sc == 1) begin mr = 1; il = 1; pi = 1; bs = 3'd7; end
                if (m_sc == 2) begin al = 1; bs = 3'd5; end
                if (m_sc == 3 && !m_d[7] && m_i) begin mr = 1; al = 1; bs = 3'd7; end
            end else begin
                if (m_sc == 0) begin ac = 1; tl = 1; bs = 3'd2; end
                if (m_sc == 1) begin mw = 1; pc = 1; bs = 3'd6; end
                if (m_sc == 2) begin pi = 1; ic = 1; end
            end
        end
        return {tt, m_d, m_i, m_s, m_r && m_s, al, 1'b0, ac, il, pi, pc, tl, mr, mw, ic, bs, m_err};
    endfunction
    // Advance one clock: model next state from the inputs the DUT sees at this edge.
    task automatic tick();
        int nsc;
        bit ns, ni, nr, nerr, clr;
        logic [7:0] nd;
        nsc = m_sc; ns = m_s; ni = m_i; nr = m_r; nerr = m_err; nd = m_d;
        if (rst) begin
            nsc = 0; ns = 0; ni = 0; nr = 0; nerr = 0; nd = 8'd0;
        end else if (!m_s) begin
            if (start) ns = 1;
        end else begin
            clr = (exec_done && m_sc >= 4) || (m_sc == 3 && m_d[7]) || (m_r && m_sc == 2);
            if (m_sc == 2 && !m_r) begin nd = 8'(1 << ir[14:12]); ni = ir[15]; end
            if (m_sc == 3 && m_d[7] && !m_i && ir[0]) ns = 0;
            if (m_sc == 7 && !clr) nerr = 1;
`ifdef INTR_EN
            if (m_r && m_sc == 2) nr = 0;
            else if (m_sc >= 3 && ien && (fgi || fgo)) nr = 1;
`endif
            nsc = clr ? 0 : (m_sc + 1) % 8;
        end
        @(posedge clk);
        m_sc = nsc; m_s = ns; m_i = ni; m_r = nr; m_err = nerr; m_d = nd;
        @(negedge clk);
    endtask
    task automatic restart(input logic [15:0] v);
        rst = 1; start = 0; exec_done = 0; ien = 0; fgi = 0; fgo = 0; ir = v;
        tick();
        rst = 0; start = 1;
        tick();
        start = 0;
    endtask
    task automatic test_reset();
        rst = 1; start = 1; exec_done = 1; ien = 1; fgi = 1; fgo = 1; ir = 16'h7001;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (obs !== 33'd0) begin failures++; $display("FAIL reset_zero cyc%0d got=%h want=0", k, obs); end
            tick();
        end
        rst = 0; start = 0; exec_done = 0; ien = 0; fgi = 0; fgo = 0;
        #1;
        e = exp_vec(); checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_idle got=%h want=%h", obs, e); end
        tick();
    endtask
    task automatic test_lda();
        restart(16'h2005);
        for (int k = 0; k < 8; k++) begin
            exec_done = (k == 5);
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL lda cyc%0d got=%h want=%h", k, obs, e); end
            if (k == 0) begin
                checks++;
                if ({t, ar_ld, bus_sel} !== {8'h01, 1'b1, 3'd2}) begin failures++; $display("FAIL lda_t0 got=%h", {t, ar_ld, bus_sel}); end
            end
            if (k == 1) begin
                checks++;
                if ({ir_ld, pc_inc, mem_rd, bus_sel} !== 6'b111_111) begin failures++; $display("FAIL lda_t1 got=%b want=111111", {ir_ld, pc_inc, mem_rd, bus_sel}); end
            end
            if (k == 3) begin
                checks++;
                if ({d, i_ff, ar_ld, mem_rd, ir_ld, pc_inc, bus_sel} !== {8'h04, 8'h00}) begin
                    failures++; $display("FAIL lda_t3 got=%h want=0400", {d, i_ff, ar_ld, mem_rd, ir_ld, pc_inc, bus_sel});
                end
            end
            if (k == 6) begin
                checks++;
                if (t !== 8'h01) begin failures++; $display("FAIL lda_refetch t=%h want=01", t); end
            end
            tick();
        end
        exec_done = 0;
    endtask
    task automatic test_indirect();
        restart(16'hA005);
        for (int k = 0; k < 6; k++) begin
            exec_done = (k == 4);
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL ind cyc%0d got=%h want=%h", k, obs, e); end
            if (k == 3) begin
                checks++;
                if ({i_ff, mem_rd, ar_ld, bus_sel} !== 6'b111_111) begin failures++; $display("FAIL ind_t3 got=%b want=111111", {i_ff, mem_rd, ar_ld, bus_sel}); end
            end
            tick();
        end
        exec_done = 0;
    endtask
    task automatic test_hlt();
        restart(16'h7001);
        for (int k = 0; k < 8; k++) begin
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL hlt cyc%0d got=%h want=%h", k, obs, e); end
            if (k == 3) begin
                checks++;
                if (d !== 8'h80) begin failures++; $display("FAIL hlt_d got=%h want=80", d); end
            end
            if (k >= 4) begin
                checks++;
                if ({s_ff, t} !== 9'd0) begin failures++; $display("FAIL hlt_stop cyc%0d got=%h want=0", k, {s_ff, t}); end
            end
            tick();
        end
        start = 1;
        tick();
        start = 0;
        #1;
        checks++;
        if (t !== 8'h01) begin failures++; $display("FAIL hlt_restart t=%h want=01", t); end
    endtask
    task automatic test_reg();
        restart(16'h7800);
        for (int k = 0; k < 6; k++) begin
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL reg cyc%0d got=%h want=%h", k, obs, e); end
            if (k == 4) begin
                checks++;
                if ({t, ar_ld, bus_sel} !== {8'h01, 1'b1, 3'd2}) begin failures++; $display("FAIL reg_t0 got=%h", {t, ar_ld, bus_sel}); end
            end
            tick();
        end
    endtask
    task automatic test_seq_err();
        restart(16'h2005);
        for (int k = 0; k < 12; k++) begin
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL err cyc%0d got=%h want=%h", k, obs, e); end
            if (k >= 8) begin
                checks++;
                if (seq_err !== 1'b1) begin failures++; $display("FAIL err_sticky cyc%0d got=%b want=1", k, seq_err); end
            end
            if (k == 8) begin
                checks++;
                if (t !== 8'h01) begin failures++; $display("FAIL err_wrap t=%h want=01", t); end
            end
            tick();
        end
        rst = 1;
        #1;
        checks++;
        if ({t, ar_ld, mem_rd, ir_ld, pc_inc, bus_sel} !== 15'd0) begin
            failures++; $display("FAIL rst_strobes got=%h want=0", {t, ar_ld, mem_rd, ir_ld, pc_inc, bus_sel});
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (seq_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", seq_err); end
    endtask
    task automatic test_intr();
        restart(16'h2005);
        for (int k = 0; k < 10; k++) begin
            ien = (k >= 4 && k < 6);
            fgi = ien;
            exec_done = (k == 5);
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL intr cyc%0d got=%h want=%h", k, obs, e); end
`ifdef INTR_EN
            if (k == 6) begin
                checks++;
                if ({ar_clr, tr_ld, ar_ld, bus_sel} !== 6'b110_010) begin failures++; $display("FAIL intr_r0 got=%b want=110010", {ar_clr, tr_ld, ar_ld, bus_sel}); end
            end
            if (k == 7) begin
                checks++;
                if ({mem_wr, pc_clr, mem_rd, bus_sel} !== 6'b110_110) begin failures++; $display("FAIL intr_r1 got=%b want=110110", {mem_wr, pc_clr, mem_rd, bus_sel}); end
            end
            if (k == 8) begin
                checks++;
                if ({pc_inc, ien_clr, ar_ld} !== 3'b110) begin failures++; $display("FAIL intr_r2 got=%b want=110", {pc_inc, ien_clr, ar_ld}); end
            end
            if (k == 9) begin
                checks++;
                if ({r_ff, t} !== 9'h001) begin failures++; $display("FAIL intr_done got=%h want=001", {r_ff, t}); end
            end
`else
            if (k == 6) begin
                checks++;
                if ({ar_ld, ar_clr, tr_ld, r_ff, bus_sel} !== 7'b1000_010) begin failures++; $display("FAIL nointr_t0 got=%b want=1000010", {ar_ld, ar_clr, tr_ld, r_ff, bus_sel}); end
            end
`endif
            tick();
        end
        exec_done = 0; ien = 0; fgi = 0;
    endtask
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 9) < 3);
            exec_done = ($urandom_range(0, 3) == 0);
            ien = 1'($urandom_range(0, 1));
            fgi = ($urandom_range(0, 7) == 0);
            fgo = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0: ir = 16'h2005;
                1: ir = 16'hA005;
                2: ir = 16'h7001;
                3: ir = 16'h7800;
                default: ir = 16'($urandom);
            endcase
            #1;
            e = exp_vec(); checks++;
            if (obs !== e) begin failures++; $display("FAIL rand cyc%0d got=%h want=%h", k, obs, e); end
            tick();
        end
    endtask
    initial begin
        rst = 1; start = 0; exec_done = 0; ien = 0; fgi = 0; fgo = 0; ir = 16'h0;
        @(negedge clk);
        test_reset();
        test_lda();
        test_indirect();
        test_hlt();
        test_reg();
        test_seq_err();
        test_intr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
